// File: rtl/chip_quad2_tester.sv
// chip_quad2_tester: functional tester for the 7400/7408/7432/7486 quad
// 2-input gate family. Walks all four {a,b} vectors across the four gates,
// synchronises the socket outputs and compares them to GATE_TT.
module chip_quad2_tester #(
  parameter logic [3:0]  GATE_TT       = 4'b0111,
  parameter int unsigned SETTLE_CYCLES = 3
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Run,
  input  logic       DISP_RSLT,
  output logic       Pin1,
  output logic       Pin2,
  output logic       Pin4,
  output logic       Pin5,
  output logic       Pin9,
  output logic       Pin10,
  output logic       Pin12,
  output logic       Pin13,
  input  logic       Pin3,
  input  logic       Pin6,
  input  logic       Pin8,
  input  logic       Pin11,
  output logic       Done,
  output logic       RSLT,
  output logic [1:0] FAIL_VEC,
  output logic [3:0] FAIL_GATE
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  vec_q, vec_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  sync1_q, sync1_d;
  logic [3:0]  sync2_q, sync2_d;
  logic [7:0]  drv_q, drv_d;
  logic        done_q, done_d;
  logic        rslt_q, rslt_d;
  logic [1:0]  fail_vec_q, fail_vec_d;
  logic [3:0]  fail_gate_q, fail_gate_d;
  logic [3:0]  expect_w;
  logic [3:0]  mism_w;

  // Pin pattern for vector {a,b}: gates A/C get {a,b}, B/D get ~{a,b}.
  // Bit order {Pin13,Pin12,Pin10,Pin9,Pin5,Pin4,Pin2,Pin1}.
  function automatic logic [7:0] drive(input logic [1:0] v);
    logic a;
    logic b;
    a = v[1];
    b = v[0];
    return {~b, ~a, b, a, ~b, ~a, b, a};
  endfunction

  assign {Pin13, Pin12, Pin10, Pin9, Pin5, Pin4, Pin2, Pin1} = drv_q;
  assign Done      = done_q;
  assign RSLT      = rslt_q;
  assign FAIL_VEC  = fail_vec_q;
  assign FAIL_GATE = fail_gate_q;

  // Expected socket outputs {D,C,B,A} for the current vector and mismatch mask.
  always_comb begin
    expect_w = {GATE_TT[~vec_q], GATE_TT[vec_q], GATE_TT[~vec_q], GATE_TT[vec_q]};
    mism_w   = sync2_q ^ expect_w;
  end

  // Next-state, drive and result logic.
  always_comb begin
    state_d     = state_q;
    vec_d       = vec_q;
    cnt_d       = cnt_q;
    drv_d       = drv_q;
    done_d      = done_q;
    rslt_d      = rslt_q;
    fail_vec_d  = fail_vec_q;
    fail_gate_d = fail_gate_q;
    sync1_d     = {Pin11, Pin8, Pin6, Pin3};
    sync2_d     = sync1_q;

    // Drives are registered on the edge that enters APPLY, so the value for
    // the upcoming vector is computed on every transition into APPLY.
    unique case (state_q)
      S_IDLE: begin
        drv_d  = '0;
        done_d = 1'b0;
        if (Run) begin
          vec_d       = '0;
          rslt_d      = 1'b1;
          fail_vec_d  = '0;
          fail_gate_d = '0;
          drv_d       = drive(2'd0);
          state_d     = S_APPLY;
        end
      end
      S_APPLY: begin
        cnt_d   = 4'(SETTLE_CYCLES - 1);
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        if (cnt_q == '0) begin
          state_d = S_SAMPLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_SAMPLE: begin
        if ((mism_w != '0) && rslt_q) begin
          rslt_d      = 1'b0;
          fail_vec_d  = vec_q;
          fail_gate_d = mism_w;
        end
        if (vec_q == 2'd3) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          vec_d   = vec_q + 2'd1;
          drv_d   = drive(vec_q + 2'd1);
          state_d = S_APPLY;
        end
      end
      S_DONE: begin
        done_d = 1'b1;
        if (!Run && !DISP_RSLT) begin
          done_d  = 1'b0;
          drv_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, synchroniser and output registers with asynchronous reset.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      vec_q       <= '0;
      cnt_q       <= '0;
      sync1_q     <= '0;
      sync2_q     <= '0;
      drv_q       <= '0;
      done_q      <= 1'b0;
      rslt_q      <= 1'b0;
      fail_vec_q  <= '0;
      fail_gate_q <= '0;
    end else begin
      state_q     <= state_d;
      vec_q       <= vec_d;
      cnt_q       <= cnt_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      drv_q       <= drv_d;
      done_q      <= done_d;
      rslt_q      <= rslt_d;
      fail_vec_q  <= fail_vec_d;
      fail_gate_q <= fail_gate_d;
    end
  end

endmodule

// File: tb/tb_chip_quad2_tester.sv
// Bench for chip_quad2_tester: two instances (NAND table / 3 settle cycles,
// XOR table / 5 settle cycles) driving behavioural chip models on the socket.
module tb_chip_quad2_tester;

  localparam int S0 = 3;
  localparam int S1 = 5;
  localparam logic [3:0] TT0 = 4'b0111;
  localparam logic [3:0] TT1 = 4'b0110;

  // chip models: 0 NAND, 1 AND, 2 NAND with Pin8 stuck high, 3 XOR
  localparam int M_NAND = 0;
  localparam int M_AND  = 1;
  localparam int M_STK8 = 2;
  localparam int M_XOR  = 3;

  logic            clk;
  logic            rst;
  logic [1:0]      run;
  logic [1:0]      disp;
  logic [1:0][7:0] pins;
  logic [1:0][3:0] sock;
  logic [1:0]      done;
  logic [1:0]      rslt;
  logic [1:0][1:0] fvec;
  logic [1:0][3:0] fgate;

  int mode [2];

  // expected verdict for the test in progress
  bit         ef  [2];
  logic [1:0] ekv [2];
  logic [3:0] egm [2];

  // model of the tester's observable behaviour
  bit         busy [2];
  int         t    [2];
  logic       hr   [2];
  logic [1:0] hv   [2];
  logic [3:0] hg   [2];

  int n_cmp;
  int n_mis;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  chip_quad2_tester #(.GATE_TT(TT0), .SETTLE_CYCLES(S0)) u_dut0 (
    .Clk(clk), .Reset(rst), .Run(run[0]), .DISP_RSLT(disp[0]),
    .Pin1(pins[0][0]), .Pin2(pins[0][1]), .Pin4(pins[0][2]), .Pin5(pins[0][3]),
    .Pin9(pins[0][4]), .Pin10(pins[0][5]), .Pin12(pins[0][6]), .Pin13(pins[0][7]),
    .Pin3(sock[0][0]), .Pin6(sock[0][1]), .Pin8(sock[0][2]), .Pin11(sock[0][3]),
    .Done(done[0]), .RSLT(rslt[0]), .FAIL_VEC(fvec[0]), .FAIL_GATE(fgate[0])
  );

  chip_quad2_tester #(.GATE_TT(TT1), .SETTLE_CYCLES(S1)) u_dut1 (
    .Clk(clk), .Reset(rst), .Run(run[1]), .DISP_RSLT(disp[1]),
    .Pin1(pins[1][0]), .Pin2(pins[1][1]), .Pin4(pins[1][2]), .Pin5(pins[1][3]),
    .Pin9(pins[1][4]), .Pin10(pins[1][5]), .Pin12(pins[1][6]), .Pin13(pins[1][7]),
    .Pin3(sock[1][0]), .Pin6(sock[1][1]), .Pin8(sock[1][2]), .Pin11(sock[1][3]),
    .Done(done[1]), .RSLT(rslt[1]), .FAIL_VEC(fvec[1]), .FAIL_GATE(fgate[1])
  );

  function automatic int per(input int i);
    return ((i == 0) ? S0 : S1) + 2;
  endfunction

  function automatic logic [3:0] tt_of(input int i);
    return (i == 0) ? TT0 : TT1;
  endfunction

  function automatic logic gate_fn(input int m, input logic x, input logic y);
    case (m)
      M_AND:   return x & y;
      M_XOR:   return x ^ y;
      default: return ~(x & y);
    endcase
  endfunction

  // socket outputs {Pin11,Pin8,Pin6,Pin3} for pin drives {13,12,10,9,5,4,2,1}
  function automatic logic [3:0] chip(input int m, input logic [7:0] p);
    logic [3:0] o;
    o[0] = gate_fn(m, p[0], p[1]);
    o[1] = gate_fn(m, p[2], p[3]);
    o[2] = (m == M_STK8) ? 1'b1 : gate_fn(m, p[4], p[5]);
    o[3] = gate_fn(m, p[6], p[7]);
    return o;
  endfunction

  function automatic logic [7:0] drive(input int v);
    logic a;
    logic b;
    a = v[1];
    b = v[0];
    return {~b, ~a, b, a, ~b, ~a, b, a};
  endfunction

  // first failing vector and gate mask a perfect tester must report
  task automatic compute_expect(input int m, input logic [3:0] tt, output bit f,
                                output logic [1:0] kv, output logic [3:0] gm);
    f  = 1'b0;
    kv = '0;
    gm = '0;
    for (int v = 0; v < 4; v++) begin
      logic [3:0] mm;
      for (int g = 0; g < 4; g++) begin
        logic [1:0] in;
        logic       got;
        in  = (g % 2 == 0) ? 2'(v) : ~2'(v);
        got = (m == M_STK8 && g == 2) ? 1'b1 : gate_fn(m, in[1], in[0]);
        mm[g] = got ^ tt[in];
      end
      if (!f && mm != '0) begin
        f  = 1'b1;
        kv = 2'(v);
        gm = mm;
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always_comb begin
    sock[0] = chip(mode[0], pins[0]);
    sock[1] = chip(mode[1], pins[1]);
  end

  // Protocol model: idle, or t edges into a test; leaves DONE when both
  // Run and DISP_RSLT are low at an edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        busy[i] <= 1'b0;
        t[i]    <= 0;
        hr[i]   <= 1'b0;
        hv[i]   <= '0;
        hg[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (busy[i]) begin
          if (t[i] >= 4 * per(i) && !run[i] && !disp[i]) begin
            busy[i] <= 1'b0;
            hr[i]   <= !ef[i];
            hv[i]   <= ef[i] ? ekv[i] : 2'd0;
            hg[i]   <= ef[i] ? egm[i] : 4'd0;
          end else begin
            t[i] <= t[i] + 1;
          end
        end else if (run[i]) begin
          busy[i] <= 1'b1;
          t[i]    <= 0;
        end
      end
    end
  end

  // Compare every output of both instances against the model each cycle.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int         p;
      int         k;
      bit         rec;
      logic [7:0] ep;
      logic       ed;
      logic       er;
      logic [1:0] ev;
      logic [3:0] eg;
      p = per(i);
      if (busy[i]) begin
        k   = (t[i] / p > 3) ? 3 : t[i] / p;
        ep  = drive(k);
        ed  = (t[i] >= 4 * p);
        rec = ef[i] && (t[i] >= (int'(ekv[i]) + 1) * p);
        er  = !rec;
        ev  = rec ? ekv[i] : 2'd0;
        eg  = rec ? egm[i] : 4'd0;
      end else begin
        ep = '0;
        ed = 1'b0;
        er = hr[i];
        ev = hv[i];
        eg = hg[i];
      end
      check($sformatf("u%0d pins", i), 32'(pins[i]), 32'(ep));
      check($sformatf("u%0d done", i), 32'(done[i]), 32'(ed));
      check($sformatf("u%0d rslt", i), 32'(rslt[i]), 32'(er));
      check($sformatf("u%0d fail_vec", i), 32'(fvec[i]), 32'(ev));
      check($sformatf("u%0d fail_gate", i), 32'(fgate[i]), 32'(eg));
    end
  end

  // One Run pulse, then hand-computed checks on Done timing and verdict.
  task automatic run_test(input int i, input int m, input int done_edge,
                          input logic xr, input logic [1:0] xv, input logic [3:0] xg);
    mode[i] = m;
    compute_expect(m, tt_of(i), ef[i], ekv[i], egm[i]);
    @(posedge clk); #1 run[i] = 1'b1;
    @(posedge clk); #1 run[i] = 1'b0;
    repeat (done_edge - 1) @(posedge clk);
    #1 check($sformatf("u%0d m%0d done before edge %0d", i, m, done_edge), 32'(done[i]), 32'd0);
    @(posedge clk);
    #1;
    check($sformatf("u%0d m%0d done at edge", i, m), 32'(done[i]), 32'd1);
    check($sformatf("u%0d m%0d rslt lit", i, m), 32'(rslt[i]), 32'(xr));
    check($sformatf("u%0d m%0d fail_vec lit", i, m), 32'(fvec[i]), 32'(xv));
    check($sformatf("u%0d m%0d fail_gate lit", i, m), 32'(fgate[i]), 32'(xg));
    @(posedge clk);
    #1 check($sformatf("u%0d m%0d back to idle", i, m), 32'(done[i]), 32'd0);
  endtask

  initial begin
    n_cmp   = 0;
    n_mis   = 0;
    rst     = 1'b1;
    run     = '0;
    disp    = '0;
    mode[0] = M_NAND;
    mode[1] = M_XOR;
    for (int i = 0; i < 2; i++) begin
      ef[i]  = 1'b0;
      ekv[i] = '0;
      egm[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    check("reset done", 32'(done[0]), 32'd0);
    check("reset pins", 32'(pins[0]), 32'd0);
    rst = 1'b0;

    run_test(0, M_NAND, 4 * (S0 + 2), 1'b1, 2'd0, 4'b0000);
    run_test(0, M_AND,  4 * (S0 + 2), 1'b0, 2'd0, 4'b1111);
    run_test(0, M_STK8, 4 * (S0 + 2), 1'b0, 2'd3, 4'b0100);

    // reset mid-test with Run held, restart, then hold in DONE
    mode[0] = M_NAND;
    compute_expect(M_NAND, TT0, ef[0], ekv[0], egm[0]);
    @(posedge clk); #1 run[0] = 1'b1;
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("mid reset pins", 32'(pins[0]), 32'd0);
    check("mid reset rslt", 32'(rslt[0]), 32'd0);
    check("mid reset fail_gate", 32'(fgate[0]), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (21) @(posedge clk);
    #1;
    check("restart done at 20", 32'(done[0]), 32'd1);
    check("restart rslt", 32'(rslt[0]), 32'd1);
    disp[0] = 1'b1;
    repeat (5) @(posedge clk);
    #1 check("held in done", 32'(done[0]), 32'd1);
    run[0]  = 1'b0;
    disp[0] = 1'b0;
    @(posedge clk);
    #1;
    check("release done", 32'(done[0]), 32'd0);
    check("release pins", 32'(pins[0]), 32'd0);

    run_test(1, M_XOR, 4 * (S1 + 2), 1'b1, 2'd0, 4'b0000);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000");
    $fatal(1);
  end

endmodule
